lock_controller_gen: RTL and testbench

- Parametrised successor to the keypad lock controller.
- Accepts digit and command strobes from the debounced keypad front end and holds one user code of variable length in internal registers.
- Toggles the lock when the user enters a correct code. Reprograms the user code only after a valid admin code and a double-entry match.
- Adds consecutive-failure lockout and inactivity timeout. Drives the LED/blink layer through hold-timed status outputs.

---
 rtl/lock_controller_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_lock_controller_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller_gen.sv
// Keypad lock controller with a variable-length user code.
// Digits are collected into a left-justified buffer, with slot 0 in the most
// significant nibble. ENTER compares the buffer against the stored user code,
// the fixed admin code or a pending new code.
// Consecutive failures lead to a timed lockout, and idle entry states time out.
// Every output comes straight from a flop, so LED logic sees clean levels.
module lock_controller_gen #(
  parameter int DIGIT_W       = 4,
  parameter int MIN_LEN       = 3,
  parameter int MAX_LEN       = 6,
  parameter logic [MAX_LEN*DIGIT_W-1:0] USER_INIT  = 24'h123456,
  parameter int USER_INIT_LEN = 6,
  parameter logic [MAX_LEN*DIGIT_W-1:0] ADMIN_CODE = 24'h876543,
  parameter int MAX_TRIES     = 3,
  parameter int LOCKOUT_CYC   = 1000,
  parameter int TIMEOUT_CYC   = 5000,
  parameter int HOLD_CYC      = 200
) (
  input  logic                           hwclk,
  input  logic                           reset,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_digit,
  input  logic                           cmd_toggle,
  input  logic                           cmd_prog,
  input  logic                           cmd_cancel,
  output logic                           locked,
  output logic                           status_ok,
  output logic                           status_err,
  output logic                           lockout,
  output logic [1:0]                     mode,
  output logic                           code_store,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int CODE_W  = MAX_LEN * DIGIT_W;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCKOUT_CYC > TIMEOUT_CYC)
                         ? ((LOCKOUT_CYC > HOLD_CYC) ? LOCKOUT_CYC : HOLD_CYC)
                         : ((TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [LEN_W-1:0] MIN_LEN_V   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_V   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] INIT_LEN_V  = LEN_W'(USER_INIT_LEN);
  localparam logic [FC_W-1:0]  MAX_TRIES_V = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TOUT_LAST   = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_ADMIN,
    S_NEW1,
    S_NEW2,
    S_RESULT,
    S_LOCKOUT
  } state_t;

  state_t state_q, state_d;

  logic [CODE_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] user_code_q, user_code_d;
  logic [LEN_W-1:0]  user_len_q, user_len_d;
  logic [CODE_W-1:0] tmp_code_q, tmp_code_d;
  logic [LEN_W-1:0]  tmp_len_q, tmp_len_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              res_ok_q, res_ok_d;

  logic              locked_q, locked_d;
  logic              status_ok_q, status_ok_d;
  logic              status_err_q, status_err_d;
  logic              lockout_q, lockout_d;
  logic [1:0]        mode_q, mode_d;
  logic              code_store_q, code_store_d;
  logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;

  logic              in_entry;
  logic              enter_cmd;
  logic              key_acc;
  logic              len_valid;
  logic [CODE_W-1:0] mask;
  logic              user_match;
  logic              admin_match;
  logic              new_match;
  logic [FC_W-1:0]   fail_inc;
  logic              timeout_hit;

  logic              fail_evt;
  logic              clr_fail;
  logic              toggle_lock;
  logic              latch_tmp;
  logic              store_code;

  // Decode strobes against the current state and evaluate all code comparisons
  always_comb begin
    in_entry  = (state_q == S_ENTRY) || (state_q == S_ADMIN) ||
                (state_q == S_NEW1)  || (state_q == S_NEW2);
    enter_cmd = 1'b0;
    if (state_q == S_ENTRY) begin
      enter_cmd = cmd_toggle;
    end else if (in_entry) begin
      enter_cmd = cmd_prog;
    end
    key_acc   = in_entry && key_valid && !cmd_cancel && !enter_cmd;
    len_valid = (len_q >= MIN_LEN_V) && !ovf_q;
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q) begin
        mask[(MAX_LEN-1-i)*DIGIT_W +: DIGIT_W] = {DIGIT_W{1'b1}};
      end
    end
    user_match  = len_valid && (len_q == user_len_q) &&
                  ((buf_q & mask) == (user_code_q & mask));
    admin_match = !ovf_q && (len_q == MAX_LEN_V) && (buf_q == ADMIN_CODE);
    new_match   = len_valid && (len_q == tmp_len_q) &&
                  ((buf_q & mask) == (tmp_code_q & mask));
    fail_inc    = (fail_cnt_q == MAX_TRIES_V) ? fail_cnt_q : fail_cnt_q + 1'b1;
    timeout_hit = in_entry && (timer_q == TOUT_LAST) &&
                  !cmd_cancel && !enter_cmd && !key_valid;
  end

  // Next-state logic, with the side effects each transition triggers
  always_comb begin
    state_d     = state_q;
    res_ok_d    = res_ok_q;
    fail_evt    = 1'b0;
    clr_fail    = 1'b0;
    toggle_lock = 1'b0;
    latch_tmp   = 1'b0;
    store_code  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_cancel) begin
          if (cmd_toggle) begin
            state_d = S_ENTRY;
          end else if (cmd_prog) begin
            state_d = S_ADMIN;
          end
        end
      end
      S_ENTRY, S_ADMIN, S_NEW1, S_NEW2: begin
        if (cmd_cancel) begin
          state_d = S_IDLE;
        end else if (enter_cmd) begin
          case (state_q)
            S_ENTRY: begin
              if (user_match) begin
                toggle_lock = 1'b1;
                clr_fail    = 1'b1;
                state_d     = S_RESULT;
                res_ok_d    = 1'b1;
              end else begin
                fail_evt = 1'b1;
              end
            end
            S_ADMIN: begin
              if (admin_match) begin
                clr_fail = 1'b1;
                state_d  = S_NEW1;
              end else begin
                fail_evt = 1'b1;
              end
            end
            S_NEW1: begin
              if (len_valid) begin
                latch_tmp = 1'b1;
                state_d   = S_NEW2;
              end else begin
                state_d  = S_RESULT;
                res_ok_d = 1'b0;
              end
            end
            default: begin
              state_d = S_RESULT;
              if (new_match) begin
                store_code = 1'b1;
                res_ok_d   = 1'b1;
              end else begin
                res_ok_d = 1'b0;
              end
            end
          endcase
          if (fail_evt) begin
            res_ok_d = 1'b0;
            state_d  = (fail_inc == MAX_TRIES_V) ? S_LOCKOUT : S_RESULT;
          end
        end else if (timeout_hit) begin
          state_d  = S_RESULT;
          res_ok_d = 1'b0;
        end
      end
      S_RESULT: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d  = S_IDLE;
          clr_fail = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: digit buffer, timers, failure counter and code registers
  always_comb begin
    buf_d       = buf_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    timer_d     = timer_q;
    fail_cnt_d  = fail_cnt_q;
    locked_d    = locked_q;
    tmp_code_d  = tmp_code_q;
    tmp_len_d   = tmp_len_q;
    user_code_d = user_code_q;
    user_len_d  = user_len_q;
    if (state_d != state_q) begin
      buf_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
      timer_d = '0;
    end else begin
      if (key_acc) begin
        if (len_q < MAX_LEN_V) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (len_q == LEN_W'(i)) begin
              buf_d[(MAX_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
            end
          end
          len_d = len_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (state_q == S_IDLE) begin
        timer_d = '0;
      end else if (in_entry && key_valid) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    if (clr_fail) begin
      fail_cnt_d = '0;
    end else if (fail_evt) begin
      fail_cnt_d = fail_inc;
    end
    if (toggle_lock) begin
      locked_d = ~locked_q;
    end
    if (latch_tmp) begin
      tmp_code_d = buf_q;
      tmp_len_d  = len_q;
    end
    if (store_code) begin
      user_code_d = tmp_code_q;
      user_len_d  = tmp_len_q;
    end
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    mode_d = 2'd0;
    case (state_d)
      S_ENTRY:        mode_d = 2'd1;
      S_ADMIN:        mode_d = 2'd2;
      S_NEW1, S_NEW2: mode_d = 2'd3;
      default:        mode_d = 2'd0;
    endcase
    status_ok_d  = (state_d == S_RESULT) && res_ok_d;
    status_err_d = ((state_d == S_RESULT) && !res_ok_d) || (state_d == S_LOCKOUT);
    lockout_d    = (state_d == S_LOCKOUT);
    code_store_d = store_code;
  end

  // State register
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; the user code reverts to its initial value on reset
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      timer_q     <= '0;
      res_ok_q    <= 1'b0;
      fail_cnt_q  <= '0;
      locked_q    <= 1'b1;
      tmp_code_q  <= '0;
      tmp_len_q   <= '0;
      user_code_q <= USER_INIT;
      user_len_q  <= INIT_LEN_V;
    end else begin
      buf_q       <= buf_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      timer_q     <= timer_d;
      res_ok_q    <= res_ok_d;
      fail_cnt_q  <= fail_cnt_d;
      locked_q    <= locked_d;
      tmp_code_q  <= tmp_code_d;
      tmp_len_q   <= tmp_len_d;
      user_code_q <= user_code_d;
      user_len_q  <= user_len_d;
    end
  end

  // Status output registers
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      status_ok_q  <= 1'b0;
      status_err_q <= 1'b0;
      lockout_q    <= 1'b0;
      mode_q       <= 2'd0;
      code_store_q <= 1'b0;
    end else begin
      status_ok_q  <= status_ok_d;
      status_err_q <= status_err_d;
      lockout_q    <= lockout_d;
      mode_q       <= mode_d;
      code_store_q <= code_store_d;
    end
  end

  assign locked     = locked_q;
  assign status_ok  = status_ok_q;
  assign status_err = status_err_q;
  assign lockout    = lockout_q;
  assign mode       = mode_q;
  assign code_store = code_store_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_lock_controller_gen.sv
// Directed bench for lock_controller_gen: a vector table covers basic
// navigation and a full unlock. Hand-written sequences cover hold timing,
// lockout, reprogramming, overflow, cancel priority, timeout and async reset.
module tb_lock_controller_gen;

  localparam int HOLD    = 200;
  localparam int LOCKCYC = 1000;
  localparam int TOUT    = 5000;

  logic       hwclk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       cmd_toggle;
  logic       cmd_prog;
  logic       cmd_cancel;
  logic       locked;
  logic       status_ok;
  logic       status_err;
  logic       lockout;
  logic [1:0] mode;
  logic       code_store;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int kv; int kd; int tg; int pg; int cn;
    int e_locked; int e_mode; int e_ok; int e_err; int e_lockout; int e_fail; int e_store;
  } vec_t;

  vec_t vecs[12];

  lock_controller_gen #(
    .DIGIT_W(4), .MIN_LEN(3), .MAX_LEN(6),
    .USER_INIT(24'h123456), .USER_INIT_LEN(6), .ADMIN_CODE(24'h876543),
    .MAX_TRIES(3), .LOCKOUT_CYC(LOCKCYC), .TIMEOUT_CYC(TOUT), .HOLD_CYC(HOLD)
  ) dut (
    .hwclk(hwclk), .reset(reset),
    .key_valid(key_valid), .key_digit(key_digit),
    .cmd_toggle(cmd_toggle), .cmd_prog(cmd_prog), .cmd_cancel(cmd_cancel),
    .locked(locked), .status_ok(status_ok), .status_err(status_err),
    .lockout(lockout), .mode(mode), .code_store(code_store), .fail_cnt(fail_cnt)
  );

  // Free-running clock
  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic applyStimulus(input int kv, input int kd, input int tg, input int pg, input int cn);
    key_valid  = 1'(kv);
    key_digit  = 4'(kd);
    cmd_toggle = 1'(tg);
    cmd_prog   = 1'(pg);
    cmd_cancel = 1'(cn);
    tick();
    key_valid  = 1'b0;
    key_digit  = 4'd0;
    cmd_toggle = 1'b0;
    cmd_prog   = 1'b0;
    cmd_cancel = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkVal($sformatf("vec%0d locked", idx), 32'(locked), v.e_locked);
    checkVal($sformatf("vec%0d mode", idx), 32'(mode), v.e_mode);
    checkVal($sformatf("vec%0d status_ok", idx), 32'(status_ok), v.e_ok);
    checkVal($sformatf("vec%0d status_err", idx), 32'(status_err), v.e_err);
    checkVal($sformatf("vec%0d lockout", idx), 32'(lockout), v.e_lockout);
    checkVal($sformatf("vec%0d fail_cnt", idx), 32'(fail_cnt), v.e_fail);
    checkVal($sformatf("vec%0d code_store", idx), 32'(code_store), v.e_store);
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(1, d, 0, 0, 0);
  endtask

  task automatic pressToggle();
    applyStimulus(0, 0, 1, 0, 0);
  endtask

  task automatic pressProg();
    applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Digits packed one per nibble, first digit in the highest used nibble
  task automatic enterSeq(input logic [31:0] digits, input int n);
    for (int i = 0; i < n; i++) begin
      pressDigit(int'(digits[(n-1-i)*4 +: 4]));
    end
  endtask

  task automatic waitIdle();
    idle(HOLD + 5);
  endtask

  task automatic setVec(input int idx, input int kv, input int kd, input int tg, input int pg,
                        input int cn, input int el, input int em, input int eo, input int ee,
                        input int elo, input int ef, input int es);
    vecs[idx] = '{kv, kd, tg, pg, cn, el, em, eo, ee, elo, ef, es};
  endtask

  initial begin
    int cnt;
    logic ok_held;

    setVec(0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    setVec(1, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0);
    setVec(2, 1, 8, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    setVec(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    setVec(4, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int d = 1; d <= 6; d++) begin
      setVec(4 + d, 1, d, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    end
    setVec(11, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    key_valid = 1'b0; key_digit = 4'd0;
    cmd_toggle = 1'b0; cmd_prog = 1'b0; cmd_cancel = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    checkVal("reset locked", 32'(locked), 1);
    checkVal("reset mode", 32'(mode), 0);
    checkVal("reset status_ok", 32'(status_ok), 0);
    checkVal("reset status_err", 32'(status_err), 0);
    checkVal("reset lockout", 32'(lockout), 0);
    checkVal("reset fail_cnt", 32'(fail_cnt), 0);
    checkVal("reset code_store", 32'(code_store), 0);
    repeat (2) @(posedge hwclk);
    #1 reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].kv, vecs[i].kd, vecs[i].tg, vecs[i].pg, vecs[i].cn);
      checkOutput(i, vecs[i]);
    end

    // status_ok hold: 200 cycles total, already sampled once
    ok_held = 1'b1;
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      if (!status_ok) ok_held = 1'b0;
    end
    checkVal("ok held 200", 32'(ok_held), 1);
    tick();
    checkVal("ok drops after hold", 32'(status_ok), 0);
    checkVal("idle after hold", 32'(mode), 0);

    $display("[TB] lockout sequence");
    for (int k = 1; k <= 3; k++) begin
      pressToggle();
      enterSeq(32'h123, 3);
      pressToggle();
      checkVal($sformatf("short code fail_cnt %0d", k), 32'(fail_cnt), k);
      if (k < 3) begin
        checkVal($sformatf("short code err %0d", k), 32'(status_err), 1);
        checkVal($sformatf("short code no lockout %0d", k), 32'(lockout), 0);
        waitIdle();
      end
    end
    checkVal("lockout asserted", 32'(lockout), 1);
    checkVal("lockout err", 32'(status_err), 1);
    cnt = 1;
    for (int i = 0; i < LOCKCYC + 100 && lockout; i++) begin
      if (i == 500) pressToggle();
      else tick();
      if (lockout) cnt++;
    end
    checkVal("lockout length", 32'(cnt), LOCKCYC);
    checkVal("after lockout fail_cnt", 32'(fail_cnt), 0);
    checkVal("after lockout mode", 32'(mode), 0);
    checkVal("after lockout err", 32'(status_err), 0);
    checkVal("after lockout locked", 32'(locked), 0);

    $display("[TB] reprogram");
    pressProg();
    enterSeq(32'h876543, 6);
    pressProg();
    checkVal("admin ok mode", 32'(mode), 3);
    enterSeq(32'h999, 3);
    pressProg();
    checkVal("new1 to new2 mode", 32'(mode), 3);
    checkVal("no store yet", 32'(code_store), 0);
    enterSeq(32'h999, 3);
    pressProg();
    checkVal("store pulse", 32'(code_store), 1);
    checkVal("store ok", 32'(status_ok), 1);
    tick();
    checkVal("store pulse ends", 32'(code_store), 0);
    waitIdle();
    pressToggle();
    enterSeq(32'h999, 3);
    pressToggle();
    checkVal("new code toggles lock", 32'(locked), 1);
    checkVal("new code ok", 32'(status_ok), 1);
    waitIdle();
    pressToggle();
    enterSeq(32'h123456, 6);
    pressToggle();
    checkVal("old code rejected err", 32'(status_err), 1);
    checkVal("old code locked", 32'(locked), 1);
    checkVal("old code fail_cnt", 32'(fail_cnt), 1);
    waitIdle();

    $display("[TB] reprogram mismatch");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pressProg();
    enterSeq(32'h876543, 6);
    pressProg();
    enterSeq(32'h999, 3);
    pressProg();
    enterSeq(32'h998, 3);
    pressProg();
    checkVal("mismatch err", 32'(status_err), 1);
    checkVal("mismatch no store", 32'(code_store), 0);
    checkVal("mismatch fail_cnt", 32'(fail_cnt), 0);
    waitIdle();
    pressToggle();
    enterSeq(32'h123456, 6);
    pressToggle();
    checkVal("original code kept", 32'(locked), 0);
    waitIdle();

    $display("[TB] overflow");
    pressToggle();
    enterSeq(32'h1234567, 7);
    pressToggle();
    checkVal("overflow err", 32'(status_err), 1);
    checkVal("overflow fail_cnt", 32'(fail_cnt), 1);
    checkVal("overflow locked", 32'(locked), 0);
    waitIdle();

    $display("[TB] cancel priority");
    pressToggle();
    enterSeq(32'h123456, 6);
    applyStimulus(0, 0, 1, 0, 1);
    checkVal("cancel mode", 32'(mode), 0);
    checkVal("cancel no ok", 32'(status_ok), 0);
    checkVal("cancel no err", 32'(status_err), 0);
    checkVal("cancel fail_cnt", 32'(fail_cnt), 1);
    checkVal("cancel locked", 32'(locked), 0);

    $display("[TB] timeout");
    pressToggle();
    idle(TOUT - 1);
    checkVal("before timeout mode", 32'(mode), 1);
    checkVal("before timeout err", 32'(status_err), 0);
    tick();
    checkVal("timeout err", 32'(status_err), 1);
    checkVal("timeout mode", 32'(mode), 0);
    checkVal("timeout fail_cnt", 32'(fail_cnt), 1);
    waitIdle();

    $display("[TB] async reset in NEW2");
    pressProg();
    enterSeq(32'h876543, 6);
    pressProg();
    enterSeq(32'h555, 3);
    pressProg();
    checkVal("in new2 mode", 32'(mode), 3);
    #3 reset = 1'b1;
    #1;
    checkVal("async reset locked", 32'(locked), 1);
    checkVal("async reset mode", 32'(mode), 0);
    checkVal("async reset fail_cnt", 32'(fail_cnt), 0);
    @(posedge hwclk);
    #1 reset = 1'b0;
    pressToggle();
    enterSeq(32'h123456, 6);
    pressToggle();
    checkVal("code reverted unlock", 32'(locked), 0);
    checkVal("code reverted ok", 32'(status_ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
